// File: rtl/uart_pkg.sv
// Shared UART definitions: default bit timing, TX state encoding and line idle level.
// Used by the digest transmitter and reusable by the RX side.
// Contains no logic; it has no ports.
package uart_pkg;

  // 125 MHz / 115200 baud
  localparam int UART_CLKS_PER_BIT_DEF = 1085;

  localparam logic UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Generic circular FIFO (power-of-two depth) with an extra pointer bit to tell full from empty.
// Latency: a pushed entry is visible at o_pop_dat on the next cycle; o_pop_dat is read combinationally.
// Backpressure: a push while full is accepted only if a pop happens in the same cycle; otherwise it is ignored.
// Ports: clk, rst_n (async active-low), i_push/i_push_dat write side, i_pop/o_pop_dat read side,
//        o_full/o_empty status. i_pop must only be asserted while o_empty is low.
module byte_fifo #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_dat,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_pop_dat,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_push_ok;

  // Same index, different wrap bit => the writer is a full lap ahead.
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_push_ok = i_push && (!o_full || i_pop);
  assign o_pop_dat = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
  end

endmodule

// File: rtl/uart_tx_digest.sv
// Buffers SHA-256 digest bytes and sends them as 8N1 UART frames, LSB first, back to back.
// Latency: byte pushed on cycle N into an idle, empty block -> start bit on uart_tx from cycle N+2.
// Backpressure: none upstream; a byte arriving while the FIFO is full (and no pop) is dropped and
//               sets the sticky overflow flag.
// Ports: clk, rst_n (async active-low); hash_byte_in/hash_dv_in byte strobe from the hash core;
//        uart_tx serial line (idle high, registered); tx_busy (registered); tx_done end-of-stop pulse;
//        overflow sticky drop flag.
module uart_tx_digest
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF,
  parameter int FIFO_DEPTH   = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] hash_byte_in,
  input  logic       hash_dv_in,
  output logic       uart_tx,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       overflow
);

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  uart_state_t r_state;
  uart_state_t w_state_nxt;
  logic [15:0] r_baud;
  logic [2:0]  r_bit_idx;
  logic [2:0]  w_bit_nxt;
  logic [7:0]  r_shift;
  logic [7:0]  w_shift_nxt;
  logic        r_tx;
  logic        w_tx_nxt;
  logic        r_busy;
  logic        r_ovf;
  logic        w_pop;
  logic        w_done;
  logic        w_baud_end;
  logic [7:0]  w_fifo_dat;
  logic        w_full;
  logic        w_empty;

  byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (hash_dv_in),
    .i_push_dat (hash_byte_in),
    .i_pop      (w_pop),
    .o_pop_dat  (w_fifo_dat),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  assign w_baud_end = (r_baud == BAUD_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_bit_nxt   = r_bit_idx;
    w_pop       = 1'b0;
    w_done      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (w_baud_end) begin
          w_state_nxt = ST_DATA;
          w_bit_nxt   = 3'd0;
        end
      end
      ST_DATA: begin
        if (w_baud_end) begin
          if (r_bit_idx == 3'd7) w_state_nxt = ST_STOP;
          else                   w_bit_nxt   = r_bit_idx + 3'd1;
        end
      end
      ST_STOP: begin
        if (w_baud_end) begin
          w_done = 1'b1;
          // Chain straight into the next start bit so frames have no idle gap.
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = ST_START;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    w_shift_nxt = w_pop ? w_fifo_dat : r_shift;

    // Line level is computed from the next state so uart_tx can come straight from a flop.
    unique case (w_state_nxt)
      ST_START: w_tx_nxt = 1'b0;
      ST_DATA:  w_tx_nxt = w_shift_nxt[w_bit_nxt];
      default:  w_tx_nxt = UART_IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= UART_IDLE_LEVEL;
      r_busy    <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_idx <= w_bit_nxt;
      r_shift   <= w_shift_nxt;
      r_tx      <= w_tx_nxt;
      // Counter restarts at each bit boundary and every state change; parked at 0 in IDLE.
      if (w_baud_end || (w_state_nxt != r_state) || (w_state_nxt == ST_IDLE)) r_baud <= '0;
      else                                                                       r_baud <= r_baud + 16'd1;
      r_busy    <= (r_state != ST_IDLE) || !w_empty;
      if (hash_dv_in && w_full && !w_pop) r_ovf <= 1'b1;
    end
  end

  assign uart_tx  = r_tx;
  assign tx_busy  = r_busy;
  assign tx_done  = w_done;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_uart_tx_digest.sv
// Bench for uart_tx_digest at CLKS_PER_BIT=8, FIFO_DEPTH=32.
// A queue-based line model predicts uart_tx / tx_done / overflow every cycle; a line decoder
// recovers bytes from uart_tx; directed tests add literal expectations.
module tb_uart_tx_digest;

  localparam int C = 8;
  localparam int D = 32;

  logic       clk;
  logic       rst_n;
  logic [7:0] hash_byte_in;
  logic       hash_dv_in;
  logic       uart_tx;
  logic       tx_busy;
  logic       tx_done;
  logic       overflow;

  uart_tx_digest #(
    .CLKS_PER_BIT (C),
    .FIFO_DEPTH   (D)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .hash_byte_in (hash_byte_in),
    .hash_dv_in   (hash_dv_in),
    .uart_tx      (uart_tx),
    .tx_busy      (tx_busy),
    .tx_done      (tx_done),
    .overflow     (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] mq[$];
  bit         m_act = 0;
  int         m_fs  = 0;
  logic [7:0] m_cur = 8'h00;
  bit         m_ovf = 0;
  int         cyc   = 0;

  initial forever begin : model
    int  pos;
    bit  last;
    bit  pop;
    bit  acc;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      mq.delete();
      m_act = 0;
      m_fs  = 0;
      m_ovf = 0;
      cyc   = 0;
    end else begin
      pos  = cyc - m_fs;
      last = m_act && (pos == 10*C - 1);
      pop  = (!m_act || last) && (mq.size() > 0);
      acc  = 0;
      if (hash_dv_in) begin
        if (mq.size() < D || pop) acc = 1;
        else                      m_ovf = 1;
      end
      if (pop) begin
        m_cur = mq.pop_front();
        m_fs  = cyc + 1;
        m_act = 1;
      end else if (last) begin
        m_act = 0;
      end
      if (acc) mq.push_back(hash_byte_in);
      cyc++;
    end
  end

  // ---------------- per-cycle compare ----------------
  int n_done    = 0;
  int last_done = 0;

  initial forever begin : cmp
    int   pos;
    logic etx;
    logic edone;
    @(negedge clk);
    if (rst_n) begin
      pos   = cyc - m_fs;
      edone = m_act && (pos == 10*C - 1);
      if (!m_act)        etx = 1'b1;
      else if (pos < C)  etx = 1'b0;
      else if (pos < 9*C) etx = m_cur[(pos - C) / C];
      else               etx = 1'b1;
      check("line_tx", uart_tx, etx);
      check("line_done", tx_done, edone);
      check("line_ovf", overflow, m_ovf);
      if (tx_done) begin
        n_done++;
        last_done = cyc;
      end
    end
  end

  // ---------------- line decoder ----------------
  logic [7:0] rxq[$];
  bit         dec_en = 1;

  initial forever begin : dec
    logic [7:0] b;
    @(negedge clk);
    if (dec_en && rst_n && uart_tx == 1'b0) begin
      repeat (C/2) @(negedge clk);
      check("dec_start", uart_tx, 1'b0);
      for (int i = 0; i < 8; i++) begin
        repeat (C) @(negedge clk);
        b[i] = uart_tx;
      end
      repeat (C) @(negedge clk);
      check("dec_stop", uart_tx, 1'b1);
      rxq.push_back(b);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic dv, input logic [7:0] b);
    @(negedge clk);
    hash_dv_in   = dv;
    hash_byte_in = b;
  endtask

  task automatic drain();
    int n;
    n = 0;
    drive(1'b0, 8'h00);
    repeat (4) @(negedge clk);
    while (tx_busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("drain_bound", (n < 5000), 1'b1);
    repeat (2*C) @(negedge clk);
  endtask

  logic       a5_bits [8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [7:0] abc_dig [32] = '{8'hba, 8'h78, 8'h16, 8'hbf, 8'h8f, 8'h01, 8'hcf, 8'hea,
                               8'h41, 8'h41, 8'h40, 8'hde, 8'h5d, 8'hae, 8'h22, 8'h23,
                               8'hb0, 8'h03, 8'h61, 8'ha3, 8'h96, 8'h17, 8'h7a, 8'h9c,
                               8'hb4, 8'h10, 8'hff, 8'h61, 8'hf2, 8'h00, 8'h15, 8'had};
  int t0;

  initial begin
    hash_dv_in   = 1'b0;
    hash_byte_in = 8'h00;
    rst_n        = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    check("rst_tx", uart_tx, 1'b1);
    check("rst_busy", tx_busy, 1'b0);
    check("rst_done", tx_done, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Test 1: single 0xA5 frame, exact timing
    rxq.delete(); n_done = 0;
    drive(1'b1, 8'hA5);
    t0 = cyc;
    drive(1'b0, 8'h00);
    check("t1_tx_n1", uart_tx, 1'b1);
    @(negedge clk);
    check("t1_tx_start", uart_tx, 1'b0);
    check("t1_busy", tx_busy, 1'b1);
    for (int i = 0; i < 8; i++) begin
      repeat (C) @(negedge clk);
      check($sformatf("t1_bit%0d", i), uart_tx, a5_bits[i]);
    end
    repeat (C) @(negedge clk);
    check("t1_stop", uart_tx, 1'b1);
    repeat (C-1) @(negedge clk);
    check("t1_done_cyc", cyc - t0, 81);
    check("t1_done", tx_done, 1'b1);
    @(negedge clk);
    check("t1_done_off", tx_done, 1'b0);
    repeat (2) @(negedge clk);
    check("t1_busy_fall", tx_busy, 1'b0);
    drain();
    check("t1_ndone", n_done, 1);
    check("t1_nrx", rxq.size(), 1);
    if (rxq.size() > 0) check("t1_byte", rxq[0], 8'hA5);

    // Test 2: 32-byte burst, back-to-back frames
    rxq.delete(); n_done = 0;
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 8'(i));
      if (i == 0) t0 = cyc;
    end
    drain();
    check("t2_ovf", overflow, 1'b0);
    check("t2_ndone", n_done, 32);
    check("t2_span", last_done - t0, 1 + 320*C);
    check("t2_nrx", rxq.size(), 32);
    for (int i = 0; i < 32 && i < rxq.size(); i++) check($sformatf("t2_b%0d", i), rxq[i], 32'(i));

    // Test 4: push into full FIFO exactly on the STOP->START pop
    rxq.delete(); n_done = 0;
    for (int i = 0; i <= 32; i++) drive(1'b1, 8'(i));
    for (int i = 33; i <= 80; i++) drive(1'b0, 8'h00);
    drive(1'b1, 8'hEE);
    check("t4_done_at_push", tx_done, 1'b1);
    drain();
    check("t4_ovf", overflow, 1'b0);
    check("t4_ndone", n_done, 34);
    check("t4_nrx", rxq.size(), 34);
    if (rxq.size() == 34) begin
      check("t4_b32", rxq[32], 8'h20);
      check("t4_b33", rxq[33], 8'hEE);
    end

    // Test 3: 33 bytes fit (first already popped), 34th dropped
    rxq.delete(); n_done = 0;
    for (int i = 0; i <= 32; i++) drive(1'b1, 8'(i));
    drive(1'b1, 8'h77);
    drive(1'b0, 8'h00);
    check("t3_ovf_set", overflow, 1'b1);
    drain();
    check("t3_ovf_sticky", overflow, 1'b1);
    check("t3_nrx", rxq.size(), 33);
    for (int i = 0; i < 33 && i < rxq.size(); i++) check($sformatf("t3_b%0d", i), rxq[i], 32'(i));

    // Test 5: async reset mid-DATA
    dec_en = 0;
    drive(1'b1, 8'h55);
    drive(1'b0, 8'h00);
    repeat (19) @(negedge clk);
    check("t5_mid_bit1", uart_tx, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_tx", uart_tx, 1'b1);
    check("t5_rst_busy", tx_busy, 1'b0);
    check("t5_rst_done", tx_done, 1'b0);
    check("t5_rst_ovf", overflow, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("t5_post_busy", tx_busy, 1'b0);
    check("t5_post_tx", uart_tx, 1'b1);
    dec_en = 1; rxq.delete(); n_done = 0;
    drive(1'b1, 8'h3C);
    drain();
    check("t5_ndone", n_done, 1);
    check("t5_nrx", rxq.size(), 1);
    if (rxq.size() > 0) check("t5_byte", rxq[0], 8'h3C);

    // Test 6: SHA-256("abc") digest through the line
    rxq.delete(); n_done = 0;
    for (int i = 0; i < 32; i++) drive(1'b1, abc_dig[i]);
    drain();
    check("t6_nrx", rxq.size(), 32);
    for (int i = 0; i < 32 && i < rxq.size(); i++) check($sformatf("t6_b%0d", i), rxq[i], abc_dig[i]);
    check("t6_first", (rxq.size() > 0) ? rxq[0] : 8'h00, 8'hba);
    check("t6_last", (rxq.size() == 32) ? rxq[31] : 8'h00, 8'had);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
